pio_in_debounced: RTL
=====================

# pio_in_debounced

Parametrised Avalon-MM slave input port for board switches and pushbuttons. It is the next generation of the team's fixed-width edge-capture PIO. It adds per-channel synchronisers and debounce counters, a selectable edge mode, and per-bit write-1-to-clear edge capture. It sits between raw board pins (SW/KEY) and the Nios II data bus, and drives one interrupt line to the CPU.

## Interface
- WIDTH, 18: number of input channels (1..32)
- SYNC_STAGES, 2: synchroniser flops per channel (2..4)
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a change; 0 bypasses the debounce stage
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- address  in  3  register word select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous pin inputs
- readdata  out  32  registered read data; bits above WIDTH (or above 1 for the mode register) read 0
- irq  out  1  OR of (edge_capture & irq_mask)

## Operation
- Address map:
  - 0 DATA: debounced state, read-only.
  - 1 EDGE_MODE: bits[1:0]; 0 rising, 1 falling, 2 any, 3 none.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
  - 4 RAW: synchronised, undebounced state, read-only.
  - 5..7: read 0; writes ignored.
- Write decode: chipselect & ~write_n & address match. Reads have no side effects.
- Per channel pipeline: synchroniser chain, then debounce, then stable bit.
- Debounce rule, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - While the synced bit differs from the stable bit, the counter increments.
  - The counter clears on any cycle where the synced bit equals the stable bit (glitch rejection).
  - When the counter has counted DEBOUNCE_CYCLES differing cycles, the stable bit toggles and the counter clears.
  - When DEBOUNCE_CYCLES=0, the stable bit equals the synced bit, delayed by one register.
- Edge detect compares the stable bit with its one-cycle-delayed copy:
  - rising: stable & ~prev
  - falling: ~stable & prev
  - any: stable ^ prev
  - none: 0
- edge_capture[i] sets on a detected edge and clears only on a write of 1 to bit i at address 3.
- Simultaneous set and clear on the same bit: set wins.
- An EDGE_MODE change does not alter captured bits.
- irq is combinational from the registered edge_capture and irq_mask. It stays asserted until the pending bits are cleared or masked.
- Reset values:
  - Output ports: readdata 0, irq 0.
  - Internal state: sync flops, stable, prev, counters, edge_capture, irq_mask and EDGE_MODE all 0.
- An input held high through reset appears as a rising edge once debounced. This is intended: software clears EDGE_CAPTURE at init.

## Timing
- Read latency 1: readdata is registered every clock from the current address, whether or not chipselect is asserted.
- Register writes take effect at the clock edge where the strobe is sampled. A read of the same register in the following cycle returns the new value.
- Input-to-capture latency: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks.
  - Measured from the first edge sampling the new in_port level to edge_capture[i] reading high internally.
  - irq rises in the same cycle as that edge_capture bit.
- DATA updates one cycle before edge_capture.
- Any pulse shorter than DEBOUNCE_CYCLES synced cycles is fully rejected: no DATA change and no capture.
- Synchronous reset asserted mid-debounce or mid-capture clears all state at the next edge. There is no residual edge after reset deasserts unless the input level is high (see reset rule above).

## Structure
- Shared package pio_pkg holds:
  - register address constants ADDR_DATA..ADDR_RAW
  - edge-mode encodings EDGE_RISE, EDGE_FALL, EDGE_ANY, EDGE_NONE
- Sub-module pio_debounce_chan (parameters SYNC_STAGES and DEBOUNCE_CYCLES; ports clk, reset, din, synced, stable, prev). It is instantiated WIDTH times with a generate loop.
- The top level contains the register file, edge logic, read mux and irq.

## Test plan
- Clean rise (WIDTH=18, SYNC=2, DEB=4, mode rising, mask 0x1): in_port[0] 0→1 held. Expect edge_capture[0]=1 and irq=1 exactly 7 clocks later; DATA reads 0x00001.
- Glitch rejection: in_port[3] high for 3 cycles, then low. Expect DATA[3] to stay 0, EDGE_CAPTURE 0 and irq 0.
- Modes (bit 5 toggled 0→1→0 under each mode):
  - falling: capture only on 1→0
  - any: captures both transitions (clear between)
  - none: captures never
- W1C and collision: capture bits 0 and 2 set; write 0x1 to address 3. Expect EDGE_CAPTURE reads 0x4. Then issue a clear of bit 2 in the same cycle as a new bit-2 edge; expect bit 2 to remain 1.
- Mask and irq: capture bit 7 with mask 0; expect irq 0. Write mask 0x80; expect irq 1 the next cycle. Clear bit 7; expect irq 0.
- Reset mid-debounce: assert reset 2 cycles into a bit-1 debounce. Expect all registers 0 after release. With in_port[1] still high, expect capture[1]=1 seven clocks after release.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the debounced PIO input port.
// Holds the register word addresses, the edge-mode encodings and the
// per-bit edge-detect helper used by the top level.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_EDGE_MODE    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RAW          = 3'd4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2,
        EDGE_NONE = 2'd3
    } edge_mode_e;

    // Edge event for one channel, from the stable bit and its delayed copy.
    function automatic logic edge_detect(input edge_mode_e mode,
                                         input logic stable,
                                         input logic prev);
        logic hit;
        case (mode)
            EDGE_RISE: hit = stable & ~prev;
            EDGE_FALL: hit = ~stable & prev;
            EDGE_ANY:  hit = stable ^ prev;
            EDGE_NONE: hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_debounce_chan.sv
// One input channel: synchroniser chain, debounce counter, stable bit and
// a one-cycle-delayed copy of the stable bit for edge detection.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   din        : raw asynchronous pin
//   synced     : output of the synchroniser chain (undebounced)
//   stable     : debounced level
//   prev       : stable delayed by one clock
module pio_debounce_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic synced,
    output logic stable,
    output logic prev
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    // Count value reached on the last differing cycle before the toggle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q, prev_d;

    // Next-state for synchroniser, debounce counter and stable/prev bits.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = {CNT_W{1'b0}};
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = sync_q[SYNC_STAGES-1];
        end else if (sync_q[SYNC_STAGES-1] != stable_q) begin
            // Toggle on the DEBOUNCE_CYCLES-th consecutive differing cycle.
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            // Any agreeing cycle restarts the count (glitch rejection).
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign stable = stable_q;
    assign prev   = prev_q;

endmodule

// File: rtl/pio_in_debounced.sv
// Avalon-MM slave input port with per-channel synchronise/debounce,
// selectable edge mode, write-1-to-clear edge capture and masked irq.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   address, chipselect,
//   write_n, writedata  : Avalon-MM slave write/read controls
//   in_port             : raw asynchronous pins
//   readdata            : registered read data (latency 1)
//   irq                 : OR of pending, unmasked capture bits
module pio_in_debounced
    import pio_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] synced_s, stable_s, prev_s, edge_det_s, clr_s;
    logic             wr_en_s;
    logic             unused_wdata_s;

    edge_mode_e       edge_mode_q, edge_mode_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q, readdata_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        pio_debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[g]),
            .synced(synced_s[g]),
            .stable(stable_s[g]),
            .prev  (prev_s[g])
        );
    end

    assign wr_en_s        = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata;

    // Per-channel edge events under the current edge mode.
    always_comb begin
        edge_det_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            edge_det_s[i] = edge_detect(edge_mode_q, stable_s[i], prev_s[i]);
        end
    end

    // Register-file write decode and edge-capture update (set beats clear).
    always_comb begin
        edge_mode_d = edge_mode_q;
        irq_mask_d  = irq_mask_q;
        clr_s       = {WIDTH{1'b0}};
        if (wr_en_s) begin
            case (address)
                ADDR_EDGE_MODE:    edge_mode_d = edge_mode_e'(writedata[1:0]);
                ADDR_IRQ_MASK:     irq_mask_d  = writedata[WIDTH-1:0];
                ADDR_EDGE_CAPTURE: clr_s       = writedata[WIDTH-1:0];
                default:           clr_s       = {WIDTH{1'b0}};
            endcase
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        edge_capture_d = (edge_capture_q & ~clr_s) | edge_det_s;
    end

    // Read mux; unused upper bits and unmapped words return zero.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA:         readdata_d[WIDTH-1:0] = stable_s;
            ADDR_EDGE_MODE:    readdata_d[1:0]       = edge_mode_q;
            ADDR_IRQ_MASK:     readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAPTURE: readdata_d[WIDTH-1:0] = edge_capture_q;
            ADDR_RAW:          readdata_d[WIDTH-1:0] = synced_s;
            default:           readdata_d            = 32'd0;
        endcase
    end

    // Register file and read-data register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_mode_q    <= EDGE_RISE;
            irq_mask_q     <= {WIDTH{1'b0}};
            edge_capture_q <= {WIDTH{1'b0}};
            readdata_q     <= 32'd0;
        end else begin
            edge_mode_q    <= edge_mode_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
